ref_row_loader: RTL and testbench

- Upstream feeder for subpixel_interpolation.
- Accepts a 15x15 block of 8-bit reference pixels as a stream of 5-pixel beats with a valid/ready handshake.
- Assembles the beats into 120-bit rows held in a ping-pong (two-bank) buffer, so one block can load while the interpolator reads the other.
- Serves in_row for the interpolator's next_row index and flags when a complete block is available.

---
 rtl/ref_row_loader_pkg.sv | 33 +++
 rtl/ref_row_loader_row_bank.sv | 29 ++
 rtl/ref_row_loader.sv | 88 ++++++++
 tb/tb_ref_row_loader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ref_row_loader_pkg.sv
// Shared geometry and control-state types for the reference row loader.
// A block is NUM_ROWS rows of ROW_PIX pixels, delivered BEAT_PIX pixels per beat.
package ref_row_loader_pkg;

  localparam int PIX_W    = 8;
  localparam int ROW_PIX  = 15;
  localparam int NUM_ROWS = 15;
  localparam int BEAT_PIX = 5;

  localparam int ROW_W         = ROW_PIX * PIX_W;
  localparam int BEAT_W        = BEAT_PIX * PIX_W;
  localparam int BEATS_PER_ROW = ROW_PIX / BEAT_PIX;
  localparam int BEATS_PER_BLK = BEATS_PER_ROW * NUM_ROWS;

  localparam int ROW_IDX_W = $clog2(NUM_ROWS);
  localparam int SEG_IDX_W = $clog2(BEATS_PER_ROW);

  typedef logic [ROW_IDX_W-1:0] row_idx_t;
  typedef logic [SEG_IDX_W-1:0] seg_idx_t;

  localparam row_idx_t LAST_ROW = row_idx_t'(NUM_ROWS - 1);
  localparam seg_idx_t LAST_SEG = seg_idx_t'(BEATS_PER_ROW - 1);

  typedef struct packed {
    logic [1:0] full;
    logic       wr_bank;
    logic       rd_bank;
    row_idx_t   row_idx;
    seg_idx_t   seg_idx;
    logic       err;
  } ctl_t;

endpackage

// File: rtl/ref_row_loader_row_bank.sv
// One bank of NUM_ROWS x ROW_W storage: segment-granular write, combinational row read.
module ref_row_loader_row_bank
  import ref_row_loader_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  row_idx_t          row_i,
  input  seg_idx_t          seg_i,
  input  logic [BEAT_W-1:0] data_i,
  input  row_idx_t          rd_row_i,
  output logic [ROW_W-1:0]  rd_data_o
);

  logic [ROW_W-1:0] rows_q [NUM_ROWS];

  // NOTE: storage has no reset; validity is tracked by the full flags in the top.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int s = 0; s < BEATS_PER_ROW; s++) begin
        if (seg_i == seg_idx_t'(s)) begin
          rows_q[row_i][ROW_W-1-s*BEAT_W -: BEAT_W] <= data_i;
        end
      end
    end
  end

  assign rd_data_o = rows_q[rd_row_i];

endmodule

// File: rtl/ref_row_loader.sv
// Ping-pong row loader: assembles pixel beats into rows of one bank while the
// interpolator reads complete blocks from the other.
module ref_row_loader
  import ref_row_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BEAT_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [7:0]        next_row,
  output logic [ROW_W-1:0]  in_row,
  output logic              blk_valid,
  input  logic              blk_release,
  output logic [1:0]        full_cnt,
  output logic              err
);

  localparam logic [7:0] ROWS_LIMIT = 8'(NUM_ROWS);

  ctl_t             ctl_q, ctl_d;
  logic             beat_acc, last_beat, beat_wr, rel_acc;
  logic [1:0]       bank_we;
  logic [ROW_W-1:0] bank_rd [2];

  assign s_ready   = ~ctl_q.full[ctl_q.wr_bank];
  assign blk_valid = ctl_q.full[ctl_q.rd_bank];
  assign full_cnt  = {1'b0, ctl_q.full[0]} + {1'b0, ctl_q.full[1]};
  assign err       = ctl_q.err;

  assign beat_acc  = s_valid & s_ready;
  assign last_beat = (ctl_q.row_idx == LAST_ROW) && (ctl_q.seg_idx == LAST_SEG);
  assign rel_acc   = blk_release & blk_valid;
  // An early s_last beat is dropped rather than stored.
  assign beat_wr   = beat_acc & ~(s_last & ~last_beat);

  // NOTE: always_comb uses blocking assignments and a full default first, so no latch can form.
  always_comb begin
    ctl_d = ctl_q;
    if (beat_acc) begin
      if (last_beat) begin
        ctl_d.full[ctl_q.wr_bank] = 1'b1;
        ctl_d.wr_bank             = ~ctl_q.wr_bank;
        ctl_d.row_idx             = '0;
        ctl_d.seg_idx             = '0;
        if (!s_last) ctl_d.err = 1'b1;
      end else if (s_last) begin
        ctl_d.row_idx = '0;
        ctl_d.seg_idx = '0;
        ctl_d.err     = 1'b1;
      end else if (ctl_q.seg_idx == LAST_SEG) begin
        ctl_d.seg_idx = '0;
        ctl_d.row_idx = ctl_q.row_idx + 1'b1;
      end else begin
        ctl_d.seg_idx = ctl_q.seg_idx + 1'b1;
      end
    end
    // Completion targets wr_bank (empty) and release targets rd_bank (full): never the same bank.
    if (rel_acc) begin
      ctl_d.full[ctl_q.rd_bank] = 1'b0;
      ctl_d.rd_bank             = ~ctl_q.rd_bank;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ctl_q <= '0;
    else     ctl_q <= ctl_d;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = beat_wr & (ctl_q.wr_bank == 1'(b));

    ref_row_loader_row_bank u_bank (
      .clk       (clk),
      .we_i      (bank_we[b]),
      .row_i     (ctl_q.row_idx),
      .seg_i     (ctl_q.seg_idx),
      .data_i    (s_data),
      .rd_row_i  (next_row[ROW_IDX_W-1:0]),
      .rd_data_o (bank_rd[b])
    );
  end

  assign in_row = (blk_valid && next_row < ROWS_LIMIT) ? bank_rd[ctl_q.rd_bank] : '0;

endmodule

// File: tb/tb_ref_row_loader.sv
// Bench for ref_row_loader: pixel-array block model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_ref_row_loader;
  import ref_row_loader_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [BEAT_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic [7:0]        next_row = '0;
  logic [ROW_W-1:0]  in_row;
  logic              blk_valid;
  logic              blk_release = 1'b0;
  logic [1:0]        full_cnt;
  logic              err;

  always #5 clk = ~clk;

  ref_row_loader dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .next_row    (next_row),
    .in_row      (in_row),
    .blk_valid   (blk_valid),
    .blk_release (blk_release),
    .full_cnt    (full_cnt),
    .err         (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: blocks as flat pixel arrays, pixel index = row*ROW_PIX + column.
  logic [7:0] pend [NUM_ROWS*ROW_PIX];
  logic [7:0] bank_pix [2][NUM_ROWS*ROW_PIX];
  bit         m_full [2];
  int         m_wr, m_rd, m_beat;
  bit         m_err;
  bit         m_acc, m_rel;

  task automatic model_reset();
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
    m_wr = 0;
    m_rd = 0;
    m_beat = 0;
    m_err = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        m_acc = s_valid && !m_full[m_wr];
        m_rel = blk_release && m_full[m_rd];
        if (m_acc) begin
          if (s_last && m_beat != BEATS_PER_BLK-1) begin
            m_beat = 0;
            m_err = 1'b1;
          end else begin
            for (int p = 0; p < BEAT_PIX; p++)
              pend[m_beat*BEAT_PIX + p] = s_data[BEAT_W-1-p*PIX_W -: PIX_W];
            if (m_beat == BEATS_PER_BLK-1) begin
              bank_pix[m_wr] = pend;
              m_full[m_wr] = 1'b1;
              m_wr ^= 1;
              m_beat = 0;
              if (!s_last) m_err = 1'b1;
            end else begin
              m_beat++;
            end
          end
        end
        if (m_rel) begin
          m_full[m_rd] = 1'b0;
          m_rd ^= 1;
        end
      end
    end
  end

  function automatic logic [ROW_W-1:0] exp_row();
    logic [ROW_W-1:0] r = '0;
    if (!m_full[m_rd] || next_row >= 8'(NUM_ROWS)) return '0;
    for (int p = 0; p < ROW_PIX; p++)
      r = {r[ROW_W-PIX_W-1:0], bank_pix[m_rd][int'(next_row)*ROW_PIX + p]};
    return r;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("s_ready", s_ready, m_full[m_wr] ? 1'b0 : 1'b1);
        check("blk_valid", blk_valid, m_full[m_rd]);
        check("full_cnt", full_cnt, {1'b0, m_full[0]} + {1'b0, m_full[1]});
        check("err", err, m_err);
        check("in_row", in_row, exp_row());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [BEAT_W-1:0] rand_beat();
    logic [BEAT_W-1:0] d;
    d[31:0]  = $urandom;
    d[39:32] = 8'($urandom);
    return d;
  endfunction

  task automatic send_beat(input logic [BEAT_W-1:0] d, input logic l);
    int  n = 0;
    bit  was_ready;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    forever begin
      was_ready = s_ready;
      @(posedge clk);
      #1;
      if (was_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_beat: no acceptance within 200 cycles at %0t", $time);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Sends n_beats beats; s_last on relative beat last_at; optional release on the final beat.
  task automatic send_block(input int n_beats, input int last_at, input bit pattern, input bit rel_last);
    logic [BEAT_W-1:0] d;
    logic [7:0]        v;
    for (int k = 0; k < n_beats; k++) begin
      v = 8'(k);
      d = pattern ? {BEAT_PIX{v}} : rand_beat();
      if (rel_last && k == n_beats-1) blk_release = 1'b1;
      send_beat(d, k == last_at);
      blk_release = 1'b0;
      if ($urandom_range(3) == 0) begin
        s_data = rand_beat();
        repeat ($urandom_range(2, 1)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic pulse_release();
    blk_release = 1'b1;
    @(posedge clk);
    #1;
    blk_release = 1'b0;
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst s_ready", s_ready, 1'b1);
    check("rst blk_valid", blk_valid, 1'b0);
    check("rst full_cnt", full_cnt, 2'd0);
    check("rst err", err, 1'b0);
    check("rst in_row", in_row, '0);

    // Block A: beat k carries five pixels of value k.
    send_block(BEATS_PER_BLK, BEATS_PER_BLK-1, 1'b1, 1'b0);
    check("A blk_valid", blk_valid, 1'b1);
    check("A full_cnt", full_cnt, 2'd1);
    next_row = 8'd0;
    #1 check("A row0", in_row, 120'h000000000001010101010202020202);
    next_row = 8'd14;
    #1 check("A row14", in_row, 120'h2A2A2A2A2A2B2B2B2B2B2C2C2C2C2C);
    next_row = 8'd15;
    #1 check("A row15", in_row, '0);
    next_row = 8'd255;
    #1 check("A row255", in_row, '0);
    next_row = 8'd0;

    // Block B fills the second bank; block C stalls until A is released.
    send_block(BEATS_PER_BLK, BEATS_PER_BLK-1, 1'b0, 1'b0);
    check("B s_ready", s_ready, 1'b0);
    check("B full_cnt", full_cnt, 2'd2);
    s_valid = 1'b1;
    s_data  = rand_beat();
    s_last  = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("stall s_ready", s_ready, 1'b0);
    pulse_release();
    check("rel s_ready", s_ready, 1'b1);
    check("rel blk_valid", blk_valid, 1'b1);
    check("rel full_cnt", full_cnt, 2'd1);
    send_beat(s_data, 1'b0);
    send_block(BEATS_PER_BLK-1, BEATS_PER_BLK-2, 1'b0, 1'b0);
    check("C full_cnt", full_cnt, 2'd2);
    pulse_release();
    pulse_release();
    check("drain full_cnt", full_cnt, 2'd0);

    // Early s_last aborts the block; the next clean block lands in bank 0.
    sync_reset();
    send_block(21, 20, 1'b1, 1'b0);
    check("early err", err, 1'b1);
    check("early blk_valid", blk_valid, 1'b0);
    check("early full_cnt", full_cnt, 2'd0);
    send_block(BEATS_PER_BLK, BEATS_PER_BLK-1, 1'b1, 1'b0);
    check("D blk_valid", blk_valid, 1'b1);
    check("D full_cnt", full_cnt, 2'd1);
    next_row = 8'd1;
    #1 check("D row1", in_row, 120'h030303030304040404040505050505);

    // Release coincident with the final beat of the other bank.
    send_block(BEATS_PER_BLK, BEATS_PER_BLK-1, 1'b0, 1'b1);
    check("coinc full_cnt", full_cnt, 2'd1);
    check("coinc blk_valid", blk_valid, 1'b1);
    check("coinc s_ready", s_ready, 1'b1);

    // Asynchronous reset partway through a block.
    send_block(30, 99, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("arst s_ready", s_ready, 1'b1);
    check("arst full_cnt", full_cnt, 2'd0);
    check("arst err", err, 1'b0);
    check("arst blk_valid", blk_valid, 1'b0);
    next_row = 8'd3;
    #1 check("arst in_row", in_row, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    send_block(BEATS_PER_BLK, BEATS_PER_BLK-1, 1'b0, 1'b0);
    check("post-rst blk_valid", blk_valid, 1'b1);
    check("post-rst err", err, 1'b0);

    // Randomized traffic with occasional framing errors and random releases.
    for (int i = 0; i < 2500; i++) begin
      s_valid     = ($urandom_range(3) != 0);
      s_data      = rand_beat();
      s_last      = (m_beat == BEATS_PER_BLK-1) ^ ($urandom_range(39) == 0);
      blk_release = ($urandom_range(5) == 0);
      next_row    = ($urandom_range(7) == 0) ? 8'($urandom) : 8'($urandom_range(15));
      @(posedge clk);
      #1;
    end
    s_valid     = 1'b0;
    s_last      = 1'b0;
    blk_release = 1'b0;
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
